// File: rtl/proc18_pkg.sv
// Shared 18-bit processor definitions.
// Used by the sequential multiplier and the ALU decode stall logic.
package proc18_pkg;

  localparam int WORD_W    = 18;
  localparam int MUL_CNT_W = 5;
  localparam int MUL_ITERS = 18;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

endpackage

// File: rtl/mul18_seq_if.sv
// Request/result bundle between the execute stage
// and the sequential multiplier.
interface mul18_seq_if;
  import proc18_pkg::*;

  logic              start;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] p_hi;
  logic [WORD_W-1:0] p_lo;
  logic              ovf;

  modport master (
    output start, a, b,
    input  busy, done, p_hi, p_lo, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, p_hi, p_lo, ovf
  );

endinterface

// File: rtl/adder18_rc.sv
// Ripple-carry adder; the multiplier's per-iteration
// partial-product add.
import proc18_pkg::*;

module adder18_rc #(
  parameter int W = WORD_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out
);

  logic [W:0] cy;

  assign cy[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]    = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i])
                   | (cy[i] & (a[i] ^ b[i]));
  end

  assign c_out = cy[W];

endmodule

// File: rtl/mul18_seq.sv
// Sequential 18x18 unsigned shift-add multiplier,
// one partial product per cycle, 36-bit exact result.
import proc18_pkg::*;

module mul18_seq #(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  mul18_seq_if.slave   bus
);

  mul_state_t       state;
  mul_state_t       state_nx;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             done_q;
  logic [WIDTH-1:0] p_hi_q;
  logic [WIDTH-1:0] p_lo_q;
  logic             ovf_q;

  assign opb  = mq[0] ? mcand : '0;
  assign last = (cnt == CNT_W'(WIDTH - 1));

  adder18_rc #(
    .W     (WIDTH)
  ) u_add (
    .a     (acc),
    .b     (opb),
    .c_in  (1'b0),
    .s     (sum),
    .c_out (c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Carry-out is shifted into acc MSB so no product bit is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mq     <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      p_hi_q <= '0;
      p_lo_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.a;
            acc   <= '0;
            mq    <= bus.b;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= {c, sum[WIDTH-1:1]};
          mq  <= {sum[0], mq[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          p_hi_q <= acc;
          p_lo_q <= mq;
          ovf_q  <= |acc;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.p_hi = p_hi_q;
  assign bus.p_lo = p_lo_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_mul18_seq.sv
// Self-checking bench for mul18_seq: vector table,
// handshake timing, held start, mid-run reset, random.
module tb_mul18_seq;

  typedef struct {
    logic [17:0] hi;
    logic [17:0] lo;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] hi;
    logic [17:0] lo;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vt[7];

  mul18_seq_if bus ();

  mul18_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("p_hi", 64'(bus.p_hi), 64'(e.hi));
        chk("p_lo", 64'(bus.p_lo), 64'(e.lo));
        chk("ovf", 64'(bus.ovf), 64'(e.ovf));
      end
    end
  end

  task automatic mul(input logic [17:0] ai,
                     input logic [17:0] bi,
                     input logic [17:0] eh,
                     input logic [17:0] el,
                     input logic        eo);
    int n;
    int nb;
    logic [31:0] r;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ai;
    bus.b     = bi;
    sb.push_back('{eh, el, eo});
    @(negedge clk);
    r = $urandom();
    bus.start = 1'b0;
    bus.a     = r[17:0];
    bus.b     = r[31:14];
    n  = 1;
    nb = bus.busy ? 1 : 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.busy) nb++;
    end
    chk("latency", 64'(n), 64'd20);
    chk("busy_cycles", 64'(nb), 64'd18);
  endtask

  initial begin
    logic [31:0] r;
    logic [35:0] prod;
    logic [17:0] ra;
    logic [17:0] rb;

    vt[0] = '{18'd3, 18'd5, 18'd0, 18'd15, 1'b0};
    vt[1] = '{18'h3FFFF, 18'h3FFFF, 18'h3FFFE, 18'h00001, 1'b1};
    vt[2] = '{18'h20000, 18'h00002, 18'h00001, 18'h0, 1'b1};
    vt[3] = '{18'h0, 18'h1ABCD, 18'h0, 18'h0, 1'b0};
    vt[4] = '{18'd7, 18'd9, 18'd0, 18'd63, 1'b0};
    vt[5] = '{18'h00001, 18'h3FFFF, 18'h0, 18'h3FFFF, 1'b0};
    vt[6] = '{18'h3FFFF, 18'h00002, 18'h00001, 18'h3FFFE, 1'b1};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_p_hi", 64'(bus.p_hi), 64'd0);
    chk("rst_p_lo", 64'(bus.p_lo), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);

    for (int i = 0; i < 7; i++)
      mul(vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].ovf);

    // start held high, operands churning every cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 18'h2D1F3;
    bus.b     = 18'h1C0A7;
    prod      = 36'h2D1F3 * 36'h1C0A7;
    sb.push_back('{prod[35:18], prod[17:0], |prod[35:18]});
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk("held_done", 64'(bus.done),
          64'((k == 20 || k == 40) ? 1 : 0));
      if (k < 40) begin
        r = $urandom();
        ra = r[17:0];
        r = $urandom();
        rb = r[17:0];
        bus.a = ra;
        bus.b = rb;
        if (k == 20) begin
          prod = 36'(ra) * 36'(rb);
          sb.push_back('{prod[35:18], prod[17:0],
                         |prod[35:18]});
        end
      end else begin
        bus.start = 1'b0;
      end
    end

    mul(vt[1].a, vt[1].b, vt[1].hi, vt[1].lo, vt[1].ovf);

    // reset mid-run aborts the multiply
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 18'h3FFFF;
    bus.b     = 18'h3FFFF;
    sb.push_back('{18'h3FFFE, 18'h00001, 1'b1});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 7) begin
        rst = 1'b1;
        sb.delete();
      end
    end
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_p_hi", 64'(bus.p_hi), 64'd0);
    chk("abort_p_lo", 64'(bus.p_lo), 64'd0);
    chk("abort_ovf", 64'(bus.ovf), 64'd0);
    repeat (30) @(negedge clk);
    chk("abort_idle", 64'(bus.busy), 64'd0);
    mul(18'd7, 18'd9, 18'd0, 18'd63, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      r = $urandom();
      ra = r[17:0];
      r = $urandom();
      rb = r[17:0];
      prod = 36'(ra) * 36'(rb);
      mul(ra, rb, prod[35:18], prod[17:0],
          (prod >> 18) != 0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
